// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute/update control FSM that
// drives the program counter load and instruction register strobes.
module pc_sequencer #(
    parameter int          SIZE      = 16,
    parameter int          STEP      = 2,
    parameter logic [SIZE-1:0] BOOT_ADDR = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [SIZE-1:0] pcValue,
    input  logic            memReady,
    input  logic            execDone,
    input  logic            branchTaken,
    input  logic [SIZE-1:0] branchTarget,
    input  logic            jump,
    input  logic [SIZE-1:0] jumpTarget,
    input  logic            halt,
    output logic            pcWrite,
    output logic [SIZE-1:0] nextAddress,
    output logic            fetchReq,
    output logic            irLoad,
    output logic [2:0]      state,
    output logic [15:0]     retired,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BOOT    = 3'd1,
        S_FETCH   = 3'd2,
        S_DECODE  = 3'd3,
        S_EXECUTE = 3'd4,
        S_UPDATE  = 3'd5,
        S_HALTED  = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic [15:0]     retired_q, retired_d;
    logic            halt_q, halt_d;
    logic [SIZE-1:0] seq_addr;

    // Sequential increment wraps modulo 2^SIZE by truncation.
    assign seq_addr = pcValue + SIZE'(STEP);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            retired_q <= '0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            retired_q <= retired_d;
            halt_q    <= halt_d;
        end
    end

    // Next-state, latched-address and strobe decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        retired_d = retired_q;
        halt_d    = halt_q;
        pcWrite   = 1'b0;
        fetchReq  = 1'b0;
        irLoad    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BOOT;
                    addr_d  = BOOT_ADDR;
                end
            end
            S_BOOT: begin
                pcWrite = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                fetchReq = 1'b1;
                irLoad   = memReady;
                if (memReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (execDone) begin
                    state_d = S_UPDATE;
                    halt_d  = halt;
                    if (jump) begin
                        addr_d = jumpTarget;
                    end else if (branchTaken) begin
                        addr_d = branchTarget;
                    end else begin
                        addr_d = seq_addr;
                    end
                end
            end
            S_UPDATE: begin
                pcWrite = 1'b1;
                if (retired_q != 16'hFFFF) begin
                    retired_d = retired_q + 16'd1;
                end
                state_d = halt_q ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign nextAddress = addr_q;
    assign state       = state_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer covering boot,
// sequential step, jump priority, wrap with fetch stall, halt and reset.
module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] pcValue;
    logic        memReady;
    logic        execDone;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic        jump;
    logic [15:0] jumpTarget;
    logic        halt;
    logic        pcWrite;
    logic [15:0] nextAddress;
    logic        fetchReq;
    logic        irLoad;
    logic [2:0]  state;
    logic [15:0] retired;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer #(
        .SIZE(16),
        .STEP(2),
        .BOOT_ADDR(16'h0040)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .pcValue(pcValue),
        .memReady(memReady),
        .execDone(execDone),
        .branchTaken(branchTaken),
        .branchTarget(branchTarget),
        .jump(jump),
        .jumpTarget(jumpTarget),
        .halt(halt),
        .pcWrite(pcWrite),
        .nextAddress(nextAddress),
        .fetchReq(fetchReq),
        .irLoad(irLoad),
        .state(state),
        .retired(retired),
        .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic clr_exec();
        execDone     = 1'b0;
        jump         = 1'b0;
        jumpTarget   = 16'h0;
        branchTaken  = 1'b0;
        branchTarget = 16'h0;
        halt         = 1'b0;
    endtask

    // Runs one instruction starting in FETCH; ends back after UPDATE.
    task automatic instr(input string tg, input logic [15:0] pc,
                         input int wait_n,
                         input logic j, input logic [15:0] jt,
                         input logic b, input logic [15:0] bt,
                         input logic h, input logic [15:0] exp_na);
        int nf;
        int ni;
        nf = 0;
        ni = 0;
        pcValue = pc;
        for (int i = 0; i <= wait_n; i++) begin
            memReady = (i == wait_n);
            #1;
            nf += int'(fetchReq);
            ni += int'(irLoad);
            cyc();
        end
        memReady = 1'b0;
        #1;
        chk({tg, "_fetch_cycles"}, nf, wait_n + 1);
        chk({tg, "_irload_pulses"}, ni, 1);
        chk({tg, "_decode_state"}, state, 3);
        chk({tg, "_decode_quiet"}, {pcWrite, fetchReq, irLoad}, 0);
        cyc();
        jump         = j;
        jumpTarget   = jt;
        branchTaken  = b;
        branchTarget = bt;
        halt         = h;
        execDone     = 1'b1;
        #1;
        chk({tg, "_exec_state"}, state, 4);
        cyc();
        clr_exec();
        #1;
        chk({tg, "_update_state"}, state, 5);
        chk({tg, "_update_pcwrite"}, pcWrite, 1);
        chk({tg, "_update_addr"}, nextAddress, exp_na);
        cyc();
    endtask

    initial begin
        int cnt_f;
        int cnt_w;
        reset    = 1'b1;
        start    = 1'b0;
        pcValue  = 16'h0;
        memReady = 1'b0;
        clr_exec();
        repeat (2) cyc();
        chk("rst_state", state, 0);
        chk("rst_addr", nextAddress, 0);
        chk("rst_retired", retired, 0);
        chk("rst_strobes", {pcWrite, fetchReq, irLoad, halted}, 0);

        reset = 1'b0;
        repeat (2) cyc();
        chk("idle_hold", state, 0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("boot_state", state, 1);
        chk("boot_pcwrite", pcWrite, 1);
        chk("boot_addr", nextAddress, 16'h0040);
        chk("boot_nofetch", fetchReq, 0);
        cyc();
        #1;
        chk("boot_fetch_state", state, 2);
        chk("boot_fetchreq", fetchReq, 1);
        chk("boot_pcwrite_once", pcWrite, 0);

        instr("seq", 16'h0040, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0042);
        #1;
        chk("seq_retired", retired, 1);
        chk("seq_period", state, 2);

        instr("pri", 16'h0042, 0, 1, 16'h1000, 1, 16'h2000, 0, 16'h1000);
        #1;
        chk("pri_retired", retired, 2);

        instr("wrap", 16'hFFFE, 3, 0, 16'h0, 0, 16'h0, 0, 16'h0000);
        #1;
        chk("wrap_retired", retired, 3);

        instr("halt", 16'h0000, 0, 0, 16'h0, 0, 16'h0, 1, 16'h0002);
        #1;
        chk("halt_state", state, 6);
        chk("halt_flag", halted, 1);
        chk("halt_retired", retired, 4);
        cnt_f = 0;
        cnt_w = 0;
        execDone   = 1'b1;
        jump       = 1'b1;
        jumpTarget = 16'h5555;
        for (int i = 0; i < 10; i++) begin
            #1;
            cnt_f += int'(fetchReq);
            cnt_w += int'(pcWrite);
            cyc();
        end
        clr_exec();
        #1;
        chk("halt_nofetch", cnt_f, 0);
        chk("halt_nowrite", cnt_w, 0);
        chk("halt_hold_state", state, 6);
        chk("halt_hold_addr", nextAddress, 16'h0002);
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("resume_state", state, 2);
        chk("resume_nowrite", pcWrite, 0);
        chk("resume_fetch", fetchReq, 1);

        memReady = 1'b1;
        cyc();
        memReady = 1'b0;
        cyc();
        #1;
        chk("mid_exec_state", state, 4);
        cyc();
        #1;
        chk("mid_exec_wait", state, 4);
        execDone = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_retired", retired, 0);
        chk("mid_rst_pcwrite", pcWrite, 0);
        chk("mid_rst_addr", nextAddress, 0);
        cnt_w = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            cnt_w += int'(pcWrite);
        end
        reset = 1'b0;
        clr_exec();
        for (int i = 0; i < 2; i++) begin
            cyc();
            cnt_w += int'(pcWrite);
        end
        chk("mid_rst_nopulse", cnt_w, 0);
        chk("post_rst_idle", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter SIZE, default 16: width of all instruction addresses.
REQ-002 Parameter STEP, default 2: sequential PC increment.
REQ-003 Parameter BOOT_ADDR, default 0: first fetch address after start from IDLE.
REQ-004 Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  leave IDLE or HALTED.
- pcValue  in  SIZE  current PC from the program counter register.
- memReady  in  1  instruction memory returns the fetched word this cycle.
- execDone  in  1  datapath finished executing the current instruction.
- branchTaken  in  1  conditional branch resolved taken; valid with execDone.
- branchTarget  in  SIZE  branch destination; valid with execDone.
- jump  in  1  unconditional jump; valid with execDone.
- jumpTarget  in  SIZE  jump destination; valid with execDone.
- halt  in  1  stop after the current instruction; valid with execDone.
- pcWrite  out  1  load enable to the program counter register.
- nextAddress  out  SIZE  value to load into the program counter register.
- fetchReq  out  1  instruction fetch request to memory.
- irLoad  out  1  one-cycle strobe to capture the instruction word.
- state  out  3  current FSM state encoding.
- retired  out  16  count of completed instructions.
- halted  out  1  high in HALTED.

Function
REQ-005 State encodings: IDLE=0, BOOT=1, FETCH=2, DECODE=3, EXECUTE=4, UPDATE=5, HALTED=6; code 7 is illegal and goes to IDLE on the next edge.
REQ-006 IDLE: outputs inactive; start=1 -> BOOT next edge; otherwise stay.
REQ-007 BOOT, one cycle:
- pcWrite=1 and nextAddress=BOOT_ADDR.
- -> FETCH.
REQ-008 FETCH:
- fetchReq=1 every cycle in this state.
- irLoad = memReady, combinational, in this state only.
- memReady=1 -> DECODE; else stay (unbounded wait).
REQ-009 DECODE: one cycle, no outputs asserted; -> EXECUTE.
REQ-010 EXECUTE: wait for execDone=1, then on that edge latch nextAddress by priority and latch halt; -> UPDATE. Priority:
- jump=1 -> jumpTarget.
- else branchTaken=1 -> branchTarget.
- else (pcValue + STEP) modulo 2^SIZE.
REQ-011 jump and branchTaken both high: jump wins.
REQ-012 Sequential increment wraps silently (e.g. SIZE=16, pcValue=16'hFFFE, STEP=2 gives 16'h0000).
REQ-013 UPDATE, one cycle:
- pcWrite=1 with the latched nextAddress.
- retired increments by 1, saturating at 16'hFFFF.
- -> HALTED if latched halt=1, else FETCH.
REQ-014 HALTED:
- halted=1, all other strobes 0.
- start=1 -> FETCH, resuming at the PC already written; no BOOT.
REQ-015 pcWrite is high only in BOOT and UPDATE, exactly one cycle per visit.
REQ-016 nextAddress is registered and holds its value outside BOOT and UPDATE.
REQ-017 Inputs other than start and memReady are ignored outside EXECUTE; start is ignored outside IDLE and HALTED.
REQ-018 Latency: an instruction with memReady in its first FETCH cycle and execDone in its first EXECUTE cycle takes 4 cycles, FETCH through UPDATE.

Reset
REQ-019 On reset=1, immediately and regardless of clock: state=IDLE, nextAddress=0, retired=0, latched halt=0, and pcWrite, fetchReq, irLoad, halted all 0.
REQ-020 Reset asserted in any state, including mid-FETCH wait or the UPDATE cycle, aborts the operation with no pcWrite pulse emitted afterwards.
REQ-021 After reset deasserts, the block stays in IDLE until start=1.

Verification
REQ-022 Boot: reset, then start=1 for 1 cycle with BOOT_ADDR=16'h0040 -> one pcWrite pulse with nextAddress=16'h0040, then fetchReq=1 in the following cycle.
REQ-023 Sequential: pcValue=16'h0040, memReady and execDone immediate, no branch -> UPDATE writes 16'h0042; retired=1; period 4 cycles.
REQ-024 Priority: jump=1 (jumpTarget=16'h1000) with branchTaken=1 (branchTarget=16'h2000) -> nextAddress=16'h1000.
REQ-025 Wrap and stall: pcValue=16'hFFFE with memReady delayed 3 cycles -> fetchReq high for 4 cycles, single irLoad pulse, nextAddress=16'h0000.
REQ-026 Halt/resume: halt=1 with execDone -> UPDATE writes, then halted=1 and no fetchReq for 10 cycles; start=1 -> FETCH with no pcWrite.
REQ-027 Reset mid-op: reset asserted in EXECUTE -> state=0, retired=0, pcWrite=0 immediately, with no UPDATE pulse.
